// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed seven-segment scanner with per-frame number snapshot
// Optional macro SEVEN_SEG_SCAN_LZB_EN enables leading-zero blanking.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int FREQ           = 27_000_000,
  parameter int DIGIT_HZ       = 1000,
  parameter int BLANK_CYCLES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   i_number,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_dig,
  output logic                  o_frame
);

  localparam int DWELL   = FREQ / DIGIT_HZ;
  localparam int CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF    = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] DIG_OFF    = {DIGITS{DIG_ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {S_LOAD, S_BLANK, S_ON} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   dig_d;
  logic                frame_d;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   onehot;
  logic                digit_shown;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign cur_nib = snap_q[{idx_q, 2'b00} +: 4];
  assign onehot  = DIGITS'(1) << idx_q;

`ifdef SEVEN_SEG_SCAN_LZB_EN
  // Blank digit k when it and every more significant nibble are zero.
  logic [4*DIGITS-1:0] snap_upper;
  assign snap_upper  = snap_q >> {idx_q, 2'b00};
  assign digit_shown = (idx_q == '0) || (snap_upper != '0);
`else
  assign digit_shown = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      o_seg   <= SEG_OFF;
      o_dig   <= DIG_OFF;
      o_frame <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      o_seg   <= seg_d;
      o_dig   <= dig_d;
      o_frame <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      S_LOAD: begin
        snap_d  = i_number;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_BLANK;
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_LOAD;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_BLANK;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
    endcase
  end

  // XOR with the off pattern applies each bus's polarity.
  always_comb begin
    seg_d   = SEG_OFF;
    dig_d   = DIG_OFF;
    frame_d = 1'b0;
    case (state_q)
      S_LOAD: frame_d = 1'b1;
      S_ON: begin
        if (digit_shown) begin
          seg_d = decode(cur_nib) ^ SEG_OFF;
          dig_d = onehot ^ DIG_OFF;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - randomized self-checking bench for seven_seg_scan
// Honours SEVEN_SEG_SCAN_LZB_EN when defined.
module tb_seven_seg_scan;

  localparam int DIGITS   = 4;
  localparam int FREQ     = 1000;
  localparam int DIGIT_HZ = 100;
  localparam int BLANK    = 2;
  localparam int DWELL    = FREQ / DIGIT_HZ;
  localparam int SLOT     = BLANK + DWELL;
  localparam int F        = 1 + DIGITS * SLOT;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_number = 16'h0;
  logic [6:0]  o_seg;
  logic [3:0]  o_dig;
  logic        o_frame;

  int checks = 0;
  int failures = 0;

  logic [6:0]  dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  always #5 i_clk = ~i_clk;

  seven_seg_scan #(
    .DIGITS(DIGITS), .FREQ(FREQ), .DIGIT_HZ(DIGIT_HZ), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_number(i_number),
    .o_seg(o_seg), .o_dig(o_dig), .o_frame(o_frame)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] inv(input logic [6:0] v);
    return ~v;
  endfunction

  task automatic slot(input string name, input logic [3:0] dig, input logic [6:0] seg);
    chk({name, "_dig"}, o_dig, dig);
    chk({name, "_seg"}, o_seg, seg);
  endtask

  // Model: position within the frame, -1 while reset, -2 before the first edge.
  int          mpos = -2;
  logic [15:0] msnap = 16'h0;

  always @(posedge i_clk) begin
    if (!i_rst_n) mpos = -1;
    else if (mpos < 0 || mpos == F - 1) begin
      mpos  = 0;
      msnap = i_number;
    end else mpos++;
  end

  int         gap = 0;
  logic       seen_lit = 1'b0;
  logic [3:0] last_dig = 4'hF;

  always @(negedge i_clk) begin : cmp
    int r, k, o;
    logic show, exp_frame;
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;
    if (mpos != -2) begin
      exp_frame = (mpos == 0);
      exp_dig   = 4'hF;
      exp_seg   = 7'h7F;
      if (mpos > 0) begin
        r = mpos - 1;
        k = r / SLOT;
        o = r % SLOT;
        if (o >= BLANK) begin
          show = 1'b1;
`ifdef SEVEN_SEG_SCAN_LZB_EN
          if (k > 0 && (msnap >> (4 * k)) == 16'h0) show = 1'b0;
`endif
          if (show) begin
            exp_dig = 4'(~(4'b0001 << k));
            exp_seg = ~dec[msnap[4*k +: 4]];
          end
        end
      end
      chk("model_frame", o_frame, exp_frame);
      chk("model_dig", o_dig, exp_dig);
      chk("model_seg", o_seg, exp_seg);
      chk("one_hot", 16'($countones(~o_dig) <= 1), 16'd1);
      if (o_dig == 4'hF) gap++;
      else begin
        if (seen_lit && !(o_dig == last_dig && gap == 0))
          chk("blank_gap", 16'(gap >= BLANK), 16'd1);
        seen_lit = 1'b1;
        last_dig = o_dig;
        gap = 0;
      end
    end
  end

  initial begin
    i_rst_n  = 1'b0;
    i_number = 16'h12AF;
    repeat (3) @(negedge i_clk);
    chk("rst_dig", o_dig, 4'hF);
    chk("rst_seg", o_seg, 7'h7F);
    chk("rst_frame", o_frame, 1'b0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("frame_c0", o_frame, 1'b1);

    for (int t = 1; t <= 140; t++) begin
      @(negedge i_clk);
      case (t)
        3:   slot("c3", 4'b1110, inv(7'h71));
        12:  slot("c12", 4'b1110, inv(7'h71));
        13:  slot("c13", 4'hF, 7'h7F);
        15:  slot("c15", 4'b1101, inv(7'h77));
        27:  slot("c27", 4'b1011, inv(7'h5B));
        39:  slot("c39", 4'b0111, inv(7'h06));
        48: begin
          slot("c48", 4'b0111, inv(7'h06));
          i_number = 16'h0000;
        end
        49:  chk("frame_c49", o_frame, 1'b1);
        52:  slot("f1_d0", 4'b1110, inv(7'h3F));
`ifdef SEVEN_SEG_SCAN_LZB_EN
        64:  slot("f1_d1", 4'hF, 7'h7F);
        73:  slot("f1_d1_late", 4'hF, 7'h7F);
        76:  slot("f1_d2", 4'hF, 7'h7F);
        88:  slot("f1_d3", 4'hF, 7'h7F);
`else
        64:  slot("f1_d1", 4'b1101, inv(7'h3F));
        73:  slot("f1_d1_late", 4'b1101, inv(7'h3F));
        76:  slot("f1_d2", 4'b1011, inv(7'h3F));
        88:  slot("f1_d3", 4'b0111, inv(7'h3F));
`endif
        98:  chk("frame_f2", o_frame, 1'b1);
        101: slot("f2_d0", 4'b1110, inv(7'h6F));
        125: slot("f2_d2", 4'b1011, inv(7'h6F));
        129: begin
          slot("rst_mid", 4'hF, 7'h7F);
          chk("rst_mid_frame", o_frame, 1'b0);
        end
        130: slot("rst_hold", 4'hF, 7'h7F);
        132: chk("frame_after_rst", o_frame, 1'b1);
        135: slot("after_rst_d0", 4'b1110, inv(7'h6F));
        default: ;
      endcase
      if (t == 69)  i_number = 16'h9999;
      if (t == 128) i_rst_n = 1'b0;
      if (t == 131) i_rst_n = 1'b1;
    end

    for (int c = 0; c < 1500; c++) begin
      @(negedge i_clk);
      if ($urandom_range(0, 15) == 0)
        i_number = 16'($urandom) & masks[$urandom_range(0, 4)];
      i_rst_n = ($urandom_range(0, 399) != 0);
    end

    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_number = 16'h0070;
    i_rst_n  = 1'b1;
    @(negedge i_clk);
    chk("lz_frame0", o_frame, 1'b1);
    for (int t = 1; t <= 98; t++) begin
      @(negedge i_clk);
      case (t)
        3:  slot("lz_d0", 4'b1110, inv(7'h3F));
        15: slot("lz_d1", 4'b1101, inv(7'h07));
`ifdef SEVEN_SEG_SCAN_LZB_EN
        27: slot("lz_d2", 4'hF, 7'h7F);
        39: slot("lz_d3", 4'hF, 7'h7F);
        64: slot("z_d1", 4'hF, 7'h7F);
`else
        27: slot("lz_d2", 4'b1011, inv(7'h3F));
        39: slot("lz_d3", 4'b0111, inv(7'h3F));
        64: slot("z_d1", 4'b1101, inv(7'h3F));
`endif
        48: i_number = 16'h0000;
        49: chk("z_frame", o_frame, 1'b1);
        52: slot("z_d0", 4'b1110, inv(7'h3F));
        97: chk("z_no_early_frame", o_frame, 1'b0);
        98: chk("z_frame_len", o_frame, 1'b1);
        default: ;
      endcase
    end

    repeat (2) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

- Multiplexed seven-segment display driver.
- Consumes the packed BCD/hex number bus produced by the counter block: 4 bits per digit, digit 0 in the LSBs.
- Time-multiplexes that bus onto a shared segment bus and one-hot digit enables.
- Sits between the counter and the board's common-anode/cathode display pins.
- Snapshots the number once per frame so a digit never shows a torn value.

## Interface
- DIGITS, 4, number of display digits; input bus width is 4*DIGITS.
- FREQ, 27_000_000, i_clk frequency in Hz.
- DIGIT_HZ, 1000, digit switch rate; DWELL = FREQ / DIGIT_HZ cycles lit per digit (integer, ≥1).
- BLANK_CYCLES, 64, cycles with all digits off before each digit is lit (≥1, anti-ghosting).
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0.
- DIG_ACTIVE_LOW, 1, 1 = digit enabled when its bit is 0.
- i_clk  input  1  system clock.
- i_rst_n  input  1  synchronous, active-low reset.
- i_number  input  4*DIGITS  packed nibbles; nibble k = i_number[4k+3:4k] drives digit k (0 = rightmost).
- o_seg  output  7  segments {g,f,e,d,c,b,a}; bit0 = a.
- o_dig  output  DIGITS  digit enables, one-hot when lit.
- o_frame  output  1  one-cycle pulse when a new snapshot is taken.

## Operation
- FSM states: LOAD, BLANK, ON.
- LOAD (1 cycle):
  - r_snap <= i_number; idx <= 0; o_frame = 1; next BLANK.
- BLANK (BLANK_CYCLES cycles):
  - All digits inactive; segments all off; next ON.
- ON (DWELL cycles):
  - o_dig bit idx active, others inactive.
  - o_seg = decode(r_snap nibble idx).
  - On the last cycle: if idx == DIGITS-1, next LOAD; else idx <= idx+1, next BLANK.
- Decode is active-high {g..a}, inverted when SEG_ACTIVE_LOW:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- i_number changes mid-frame are ignored until the next LOAD.
- "Off" always honours polarity parameters:
  - all-zero when active-high;
  - all-ones when active-low.
- Dwell/blank counter width is $clog2(max(DWELL, BLANK_CYCLES))+1; it resets to 0 on every state entry.

## Timing
- All outputs are registered and change on the same i_clk edge as the FSM state.
- Frame length F = 1 + DIGITS*(BLANK_CYCLES + DWELL) cycles, constant, independent of data.
- First cycle after reset release is LOAD; o_frame pulses in that cycle.
- Next o_frame is exactly F cycles later.
- Digit k is lit from frame offset 1 + k*(BLANK+DWELL) + BLANK for DWELL cycles.
- Never more than one digit active in any cycle.
- At least BLANK_CYCLES all-off cycles between any two lit digits, including across frame boundaries.
- Reset while i_rst_n = 0:
  - state LOAD, idx 0, counters 0, r_snap 0.
  - o_seg off, o_dig off, o_frame 0.
  - Applies mid-frame as well; the interrupted digit goes dark on the reset edge.

## Configuration
- Macro: SEVEN_SEG_SCAN_LZB_EN.
- Defined (leading-zero blanking):
  - During digit k's ON slot (k > 0), o_dig stays inactive and o_seg is off if nibbles k..DIGITS-1 of r_snap are all zero.
  - Digit 0 is always shown.
  - Slot timing and F are unchanged.
- Undefined: every digit is lit in its slot, zeros included.

## Test plan
Bench params: DIGITS=4, FREQ=1000, DIGIT_HZ=100 (DWELL=10), BLANK_CYCLES=2, both polarities active-low; F=49.

- Release reset with i_number=16'h12AF:
  - o_frame pulses at cycle 0.
  - Cycles 3-12: o_dig=4'b1110, o_seg=~7'h71.
  - Cycles 15-24: o_dig=4'b1101, o_seg=~7'h77.
  - Cycles 27-36: o_dig=4'b1011, o_seg=~7'h5B.
  - Cycles 39-48: o_dig=4'b0111, o_seg=~7'h06.
  - Next o_frame at cycle 49.
- Change i_number 16'h0000→16'h9999 at cycle 20:
  - Remaining slots of frame 1 still show 0 (~7'h3F).
  - Frame 2 shows ~7'h6F on all digits.
- Check every cycle:
  - popcount(~o_dig) ≤ 1.
  - ≥2 all-ones o_dig cycles between lit slots, including cycles 48→51.
- Assert i_rst_n=0 at cycle 30 for 3 cycles:
  - Next edge: o_dig=4'hF, o_seg=7'h7F, o_frame=0.
  - After release, o_frame pulses immediately and the frame restarts at digit 0.
- With SEVEN_SEG_SCAN_LZB_EN defined, i_number=16'h0070:
  - Digits 3 and 2 stay dark (o_dig=4'hF in their slots).
  - Digit 1 shows ~7'h07; digit 0 shows ~7'h3F.
- With SEVEN_SEG_SCAN_LZB_EN defined, i_number=16'h0000:
  - Only digit 0 is lit, showing ~7'h3F.
  - F remains 49.
